// File: rtl/qnigma_tcp_tx_sched.sv
// TCP transmit scheduler: walks live packet-info entries from tail to head-1,
// freeing acked entries, issuing first sends and retransmits, and aging entries.

package qnigma_tcp_tx_sched_pkg;
  localparam int unsigned TRIES_W = 4;
  localparam int unsigned RTO_W   = 8;
  localparam int unsigned SEQ_W   = 32;

  typedef struct packed {
    logic               exists;
    logic [TRIES_W-1:0] tries;
    logic [RTO_W-1:0]   norm_rto;
    logic [SEQ_W-1:0]   start;
    logic [SEQ_W-1:0]   stop;
  } tcp_pkt_t;
endpackage

module qnigma_tcp_tx_sched
  import qnigma_tcp_tx_sched_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned RTO_TICKS = 200,
  parameter int unsigned MAX_TRIES = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              con_i,
  input  logic              flush_i,
  input  logic              tick_i,
  input  logic [31:0]       ack_i,
  input  logic [ADDR_W:0]   head_i,
  output logic [ADDR_W:0]   tail_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] ram_a_o,
  input  tcp_pkt_t          ram_q_i,
  output tcp_pkt_t          ram_d_o,
  output logic              ram_we_o,
  output logic              send_req_o,
  output tcp_pkt_t          send_pkt_o,
  input  logic              send_ack_i,
  output logic              abort_o,
  output logic              flushed_o
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, RD, EVAL, SEND, WR, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [ADDR_W-1:0] fcnt_q, fcnt_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  tcp_pkt_t          ram_d_q, ram_d_d;
  logic              ram_we_q, ram_we_d;
  logic              send_req_q, send_req_d;
  tcp_pkt_t          send_pkt_q, send_pkt_d;
  logic              abort_q, abort_d;
  logic              flushed_q, flushed_d;
  logic              full_q, full_d;
  logic              tick_pend_q, tick_pend_d;
  logic              pass_tick_q, pass_tick_d;
  logic              pass_start;
  logic              next_entry;
  tcp_pkt_t          upd;
  logic [31:0]       seq_diff;

  // Modular distance from entry end to remote ack; sign bit clear means acked.
  assign seq_diff = ack_i - ram_q_i.stop;

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tail_d     = tail_q;
    fcnt_d     = fcnt_q;
    ram_a_d    = ram_a_q;
    ram_d_d    = ram_d_q;
    ram_we_d   = 1'b0;
    send_req_d = send_req_q;
    send_pkt_d = send_pkt_q;
    abort_d    = 1'b0;
    flushed_d  = 1'b0;
    pass_start = 1'b0;
    next_entry = 1'b0;
    upd        = ram_q_i;

    case (state_q)
      IDLE: begin
        if (con_i && (head_i != tail_q)) begin
          state_d    = RD;
          ptr_d      = tail_q;
          ram_a_d    = tail_q[ADDR_W-1:0];
          pass_start = 1'b1;
        end
      end
      RD: state_d = con_i ? EVAL : IDLE;
      EVAL: begin
        if (!con_i) begin
          state_d = IDLE;
        end else if (!ram_q_i.exists) begin
          if (ptr_q == tail_q) tail_d = tail_q + PTR_W'(1);
          next_entry = 1'b1;
        end else if (!seq_diff[31]) begin
          upd.exists = 1'b0;
          ram_d_d    = upd;
          ram_we_d   = 1'b1;
          state_d    = WR;
          if (ptr_q == tail_q) tail_d = tail_q + PTR_W'(1);
        end else if (ram_q_i.tries == '0) begin
          send_pkt_d = ram_q_i;
          send_req_d = 1'b1;
          state_d    = SEND;
        end else if (32'(ram_q_i.norm_rto) >= RTO_TICKS) begin
          if (32'(ram_q_i.tries) >= MAX_TRIES) begin
            abort_d = 1'b1;
            state_d = IDLE;
          end else begin
            send_pkt_d = ram_q_i;
            send_req_d = 1'b1;
            state_d    = SEND;
          end
        end else begin
          if (ram_q_i.norm_rto != '1)
            upd.norm_rto = ram_q_i.norm_rto + RTO_W'(pass_tick_q);
          ram_d_d  = upd;
          ram_we_d = 1'b1;
          state_d  = WR;
        end
      end
      SEND: begin
        if (send_ack_i) begin
          upd          = send_pkt_q;
          upd.tries    = send_pkt_q.tries + TRIES_W'(1);
          upd.norm_rto = '0;
          ram_d_d      = upd;
          ram_we_d     = 1'b1;
          send_req_d   = 1'b0;
          state_d      = WR;
        end
      end
      WR: next_entry = 1'b1;
      FLUSH: begin
        if (fcnt_q == ADDR_W'(DEPTH - 1)) begin
          tail_d    = head_i;
          flushed_d = 1'b1;
          state_d   = IDLE;
        end else begin
          fcnt_d   = fcnt_q + ADDR_W'(1);
          ram_a_d  = fcnt_d;
          ram_d_d  = '0;
          ram_we_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (next_entry) begin
      ptr_d   = ptr_q + PTR_W'(1);
      ram_a_d = ptr_d[ADDR_W-1:0];
      state_d = (!con_i || (ptr_d == head_i)) ? IDLE : RD;
    end

    // Flush preempts everything, including a pending send; the first clear write starts now.
    if (flush_i && (state_q != FLUSH)) begin
      state_d    = FLUSH;
      send_req_d = 1'b0;
      abort_d    = 1'b0;
      pass_start = 1'b0;
      fcnt_d     = '0;
      ram_a_d    = '0;
      ram_d_d    = '0;
      ram_we_d   = 1'b1;
    end

    tick_pend_d = tick_i | (tick_pend_q & ~pass_start);
    pass_tick_d = pass_start ? tick_pend_q : pass_tick_q;
    full_d      = ((head_i - tail_d) == PTR_W'(DEPTH));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      tail_q      <= '0;
      fcnt_q      <= '0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      ram_we_q    <= 1'b0;
      send_req_q  <= 1'b0;
      send_pkt_q  <= '0;
      abort_q     <= 1'b0;
      flushed_q   <= 1'b0;
      full_q      <= 1'b0;
      tick_pend_q <= 1'b0;
      pass_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tail_q      <= tail_d;
      fcnt_q      <= fcnt_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      ram_we_q    <= ram_we_d;
      send_req_q  <= send_req_d;
      send_pkt_q  <= send_pkt_d;
      abort_q     <= abort_d;
      flushed_q   <= flushed_d;
      full_q      <= full_d;
      tick_pend_q <= tick_pend_d;
      pass_tick_q <= pass_tick_d;
    end
  end

  assign tail_o     = tail_q;
  assign full_o     = full_q;
  assign ram_a_o    = ram_a_q;
  assign ram_d_o    = ram_d_q;
  assign ram_we_o   = ram_we_q;
  assign send_req_o = send_req_q;
  assign send_pkt_o = send_pkt_q;
  assign abort_o    = abort_q;
  assign flushed_o  = flushed_q;

endmodule

// File: tb/tb_qnigma_tcp_tx_sched.sv
// Bench for qnigma_tcp_tx_sched: table RAM model, transmitter model with a
// send scoreboard, table-driven entry decisions and hand-written corner sequences.
module tb_qnigma_tcp_tx_sched;
  import qnigma_tcp_tx_sched_pkg::*;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              con, flush, tick, send_ack, ram_we, send_req, abort, flushed, full;
  logic [31:0]       ack;
  logic [ADDR_W:0]   head, tail;
  logic [ADDR_W-1:0] ram_a;
  tcp_pkt_t          ram_q, ram_d, send_pkt;

  // Table RAM with an add-side write port driven by the bench.
  tcp_pkt_t          mem [DEPTH];
  logic              add_we;
  logic [ADDR_W-1:0] add_a;
  tcp_pkt_t          add_d;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    if (add_we) mem[add_a] <= add_d;
    ram_q <= mem[ram_a];
  end

  qnigma_tcp_tx_sched dut (
    .clk(clk), .rst_n(rst_n), .con_i(con), .flush_i(flush), .tick_i(tick),
    .ack_i(ack), .head_i(head), .tail_o(tail), .full_o(full),
    .ram_a_o(ram_a), .ram_q_i(ram_q), .ram_d_o(ram_d), .ram_we_o(ram_we),
    .send_req_o(send_req), .send_pkt_o(send_pkt), .send_ack_i(send_ack),
    .abort_o(abort), .flushed_o(flushed)
  );

  typedef struct {
    logic [3:0]  tries;
    logic [7:0]  rto;
    logic [31:0] ack_off;
    logic        tick;
    logic        exp_exists;
    logic [3:0]  exp_tries;
    logic [7:0]  exp_rto;
    int          exp_sends;
  } vec_t;

  vec_t     vec [NV];
  tcp_pkt_t exp_q [$];
  int errors = 0, checks = 0;
  int cyc = 0, send_cnt = 0, abort_cnt = 0, flushed_cnt = 0, wait_cnt = 0;
  bit tick_en = 1'b0, ack_en = 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tcp_pkt_t mk(input logic [3:0] t, input logic [7:0] r, input logic [31:0] s);
    tcp_pkt_t p;
    p.exists   = 1'b1;
    p.tries    = t;
    p.norm_rto = r;
    p.start    = s - 32'd10;
    p.stop     = s;
    return p;
  endfunction

  // One clock: clear pulses, run tick source, monitors and the transmitter model.
  task automatic step();
    @(negedge clk);
    cyc++;
    add_we = 1'b0;
    flush  = 1'b0;
    tick   = tick_en && (cyc % 8 == 0);
    if (abort)   abort_cnt++;
    if (flushed) flushed_cnt++;
    if (send_ack) begin
      send_ack = 1'b0;
    end else if (send_req && ack_en) begin
      wait_cnt++;
      if (wait_cnt >= 2) begin
        wait_cnt = 0;
        send_ack = 1'b1;
        send_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected no send", send_pkt);
        end else begin
          chk("sb_send_pkt", 128'(send_pkt), 128'(exp_q.pop_front()));
        end
      end
    end else if (!send_req) begin
      wait_cnt = 0;
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic add_entry(input logic [3:0] t, input logic [7:0] r, input logic [31:0] s);
    add_d  = mk(t, r, s);
    add_a  = head[ADDR_W-1:0];
    add_we = 1'b1;
    head   = head + 5'd1;
    step();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]       s;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   t0;
    int                sc0, ab0, fl0, n, live;

    vec[0] = '{4'd1, 8'd5,   32'hFFFF_FFFF, 1'b0, 1'b1, 4'd1, 8'd5,   0};
    vec[1] = '{4'd1, 8'd5,   32'hFFFF_FFFF, 1'b1, 1'b1, 4'd1, 8'd6,   0};
    vec[2] = '{4'd1, 8'd199, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd1, 8'd199, 0};
    vec[3] = '{4'd2, 8'd200, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd3, 8'd0,   1};
    vec[4] = '{4'd1, 8'd0,   32'h0000_0000, 1'b0, 1'b0, 4'd1, 8'd0,   0};
    vec[5] = '{4'd0, 8'd0,   32'h0000_0005, 1'b0, 1'b0, 4'd0, 8'd0,   0};
    vec[6] = '{4'd5, 8'd199, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd5, 8'd199, 0};
    vec[7] = '{4'd0, 8'd0,   32'hFFFF_FFFF, 1'b0, 1'b1, 4'd1, 8'd0,   1};
    vec[8] = '{4'd1, 8'd3,   32'h8000_0000, 1'b0, 1'b1, 4'd1, 8'd3,   0};
    vec[9] = '{4'd1, 8'd3,   32'h7FFF_FFFF, 1'b0, 1'b0, 4'd1, 8'd3,   0};

    con = 1'b0; flush = 1'b0; tick = 1'b0; ack = '0; head = '0; send_ack = 1'b0;
    add_we = 1'b0; add_a = '0; add_d = '0;

    // Reset state.
    wait_n(2);
    chk("rst_tail", tail, 0);
    chk("rst_full", full, 0);
    chk("rst_send_req", send_req, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_abort", abort, 0);
    chk("rst_flushed", flushed, 0);
    rst_n = 1'b1;
    wait_n(2);
    chk("post_rst_tail", tail, 0);

    // First send latency and write-back.
    con = 1'b1;
    step();
    exp_q.push_back(mk(4'd0, 8'd0, 32'd100));
    add_entry(4'd0, 8'd0, 32'd100);
    chk("lat_c1", send_req, 0);
    step();
    chk("lat_c2", send_req, 0);
    step();
    chk("lat_c3", send_req, 1);
    chk("lat_stop", send_pkt.stop, 100);
    wait_n(10);
    chk("wb_tries", mem[0].tries, 1);
    chk("wb_rto", mem[0].norm_rto, 0);
    chk("t1_sends", send_cnt, 1);

    // Ack just below and at the entry end.
    ack = 32'd99;
    wait_n(20);
    chk("ack99_exists", mem[0].exists, 1);
    chk("ack99_tail", tail, 0);
    ack = 32'd100;
    wait_n(20);
    chk("ack100_exists", mem[0].exists, 0);
    chk("ack100_tail", tail, 1);

    // Per-entry decisions from the vector table.
    for (int i = 0; i < NV; i++) begin
      s   = 32'(1000 * (i + 1));
      ack = s + vec[i].ack_off;
      idx = head[ADDR_W-1:0];
      sc0 = send_cnt;
      if (vec[i].exp_sends != 0) exp_q.push_back(mk(vec[i].tries, vec[i].rto, s));
      add_entry(vec[i].tries, vec[i].rto, s);
      if (vec[i].tick) tick = 1'b1;
      wait_n(30);
      chk($sformatf("v%0d_exists", i), mem[idx].exists, vec[i].exp_exists);
      chk($sformatf("v%0d_tries", i), mem[idx].tries, vec[i].exp_tries);
      chk($sformatf("v%0d_rto", i), mem[idx].norm_rto, vec[i].exp_rto);
      chk($sformatf("v%0d_sends", i), send_cnt - sc0, vec[i].exp_sends);
      chk($sformatf("v%0d_tail", i), tail, vec[i].exp_exists ? head - 5'd1 : head);
      ack = s + 32'd10;
      wait_n(20);
      chk($sformatf("v%0d_clean", i), tail, head);
    end
    chk("table_no_abort", abort_cnt, 0);
    chk("table_sb_empty", exp_q.size(), 0);

    // Retransmits up to the try limit, then a single abort.
    ack = 32'd4999;
    idx = head[ADDR_W-1:0];
    exp_q.push_back(mk(4'd0, 8'd0, 32'd5000));
    for (int k = 1; k < 5; k++) exp_q.push_back(mk(4'(k), 8'd200, 32'd5000));
    ab0 = abort_cnt;
    add_entry(4'd0, 8'd0, 32'd5000);
    tick_en = 1'b1;
    n = 0;
    while (abort_cnt == ab0 && n < 20000) begin
      step();
      n++;
    end
    con = 1'b0;
    tick_en = 1'b0;
    chk("abort_seen", abort_cnt - ab0, 1);
    wait_n(20);
    chk("abort_once", abort_cnt - ab0, 1);
    chk("retx_sb_empty", exp_q.size(), 0);
    chk("retx_tries", mem[idx].tries, 5);
    chk("retx_exists", mem[idx].exists, 1);
    ack = 32'd5001;
    con = 1'b1;
    wait_n(20);
    chk("retx_clean", tail, head);

    // Sequence wrap through zero.
    ack = 32'hFFFF_FF00;
    t0 = tail;
    add_entry(4'd1, 8'd0, 32'hFFFF_FFF0);
    add_entry(4'd1, 8'd0, 32'h0000_0010);
    wait_n(20);
    chk("wrap_hold", tail, t0);
    ack = 32'hFFFF_FFF0;
    wait_n(20);
    chk("wrap_first", tail, t0 + 5'd1);
    ack = 32'h0000_0010;
    wait_n(20);
    chk("wrap_both", tail, t0 + 5'd2);
    chk("wrap_head", tail, head);

    // Full table.
    ack = 32'd9999;
    for (int i = 0; i < DEPTH; i++) begin
      add_entry(4'd1, 8'd0, 32'(10000 + i));
      if (i == DEPTH - 2) begin
        step();
        chk("full_at_15", full, 0);
      end
    end
    wait_n(3);
    chk("full_set", full, 1);
    ack = 32'd10100;
    n = 0;
    while (tail != head && n < 300) begin
      step();
      n++;
    end
    chk("drain_tail", tail, head);
    wait_n(2);
    chk("full_clear", full, 0);

    // Flush while a send request is outstanding.
    ack_en = 1'b0;
    ack = 32'd20000;
    sc0 = send_cnt;
    for (int i = 0; i < 3; i++) add_entry(4'd0, 8'd0, 32'(20010 + i));
    n = 0;
    while (!send_req && n < 50) begin
      step();
      n++;
    end
    chk("flush_req_up", send_req, 1);
    wait_n(3);
    chk("flush_req_hold", send_req, 1);
    fl0 = flushed_cnt;
    flush = 1'b1;
    step();
    chk("flush_req_drop", send_req, 0);
    n = 0;
    while (flushed_cnt == fl0 && n < 60) begin
      step();
      n++;
    end
    wait_n(5);
    chk("flushed_once", flushed_cnt - fl0, 1);
    chk("flush_tail", tail, head);
    live = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i].exists !== 1'b0) live++;
    chk("flush_cleared", live, 0);
    chk("flush_no_send", send_cnt - sc0, 0);
    chk("flush_req_idle", send_req, 0);
    ack_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
